regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an integrated pending-write scoreboard for the 5-stage pipeline. It serves decode-stage reads on NREAD ports and takes writeback-stage writes. It forwards a same-cycle writeback to readers and tracks in-flight destination registers so decode can stall on RAW hazards without a separate hazard table. It is the next generation of the pipeline's register file: it adds a reset, a hardwired zero register, internal bypass, a configurable port count, and a scoreboard.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = log2(NREGS)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and is never written or marked busy
- RESET_INIT, 1, reset contents: 0 = all zero, 1 = register i holds i (zero-extended)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- writeEnable  in  1  writeback-stage instruction writes a register
- writeReg  in  AW  writeback destination
- writeData  in  XLEN  writeback data
- nop  in  1  writeback slot squashed; blocks the array write and bypass
- readReg  in  NREAD*AW  port p index at bits [p*AW +: AW]
- readData  out  NREAD*XLEN  port p data
- readBusy  out  NREAD  port p source has a pending write not satisfied this cycle
- issueValid  in  1  decode issues an instruction with a destination
- issueReg  in  AW  destination of the issuing instruction
- flush  in  1  discard all pending-write tracking
- sbOverflow  out  1  sticky: an issue hit a saturated counter

## Operation
- Storage: NREGS × XLEN array plus one 2-bit pending counter per register.
- wbFire = writeEnable & !nop & !(ZERO_REG & writeReg==0). On wbFire, the array is written at the posedge.
- Read port p, combinational:
  - index 0 with ZERO_REG → 0
  - else if wbFire and writeReg==readReg[p] → writeData (bypass)
  - else → array contents
- Retire = writeEnable (nop still retires, so squashed writes release their counter).
- Counter update per register r, in priority order:
  1. rst → 0
  2. flush → 0
  3. issue to r and retire of r in the same cycle → unchanged
  4. issue to r → +1 (at 3: stays 3, sbOverflow set)
  5. retire of r → −1 (at 0: stays 0)
- Issue or retire to register 0 with ZERO_REG is ignored.
- readBusy[p] = count[r]≠0 and not (count[r]==1 and retire of r this cycle), where r = readReg[p].
- readBusy for register 0 with ZERO_REG is always 0.
- sbOverflow is cleared only by rst.

## Timing
- Reads, bypass and readBusy are combinational from the current inputs and state; zero-cycle latency.
- Writes and counter updates take effect at the posedge; visible from the array the following cycle, and via bypass in the same cycle.
- Reset values:
  - array per RESET_INIT
  - all counters 0
  - readBusy 0
  - sbOverflow 0
  - readData reflects the reset contents from the first cycle after rst.
- rst asserted mid-operation overrides writes, issue and flush in that cycle.
- flush together with writeEnable: the array write still occurs; counters go to 0.
- Multiple read ports on the same index return identical data and busy.

## Structure
- Package regfile_pkg holds:
  - the log2 helper for AW
  - the counter width constant (2)
  - the counter max constant (3)
  - the RESET_INIT encodings
- Sub-module reg_scoreboard holds the counter array, flush/overflow logic and per-port busy evaluation.
- regfile_sb holds the array, write logic, bypass mux and reset initialisation.

## Test plan
- Reset check: rst for 1 cycle with RESET_INIT=1, then read ports on 5 and 31 → 5 and 31; readBusy=0; sbOverflow=0.
- Bypass: writeEnable, writeReg=7, writeData=0xDEADBEEF while readReg port0=7 → readData port0=0xDEADBEEF in the same cycle, and 0xDEADBEEF from the array the next cycle.
- Zero register: write 0x1234 to reg 0 and issue to reg 0 → reading reg 0 gives 0 and readBusy=0; counters unchanged.
- Nop: nop=1 with writeEnable, writeReg=3, writeData=9 after one issue to 3 → reg 3 keeps its old value, counter drops to 0, readBusy for 3 =0.
- Scoreboard: issue 4 three times in consecutive cycles → readBusy=1. Retire 4 twice → busy stays 1. In the cycle of the third retire → busy=0 and data is bypassed. A fourth issue while at 3 → sbOverflow=1 and stays 1.
- Flush: issue to 2 and 6, assert flush together with retire of 2 → next cycle both counters 0, readBusy=0, reg 2 holds the written value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file and its scoreboard.
//   log2()      : ceiling log2 used to size register index fields
//   CntW/CntMax : pending-write counter width and saturation value
//   RstZero/RstIndex : encodings for the RESET_INIT parameter
package regfile_pkg;

  localparam int unsigned CntW     = 2;
  localparam int unsigned CntMax   = 3;

  localparam int unsigned RstZero  = 0;  // all registers reset to zero
  localparam int unsigned RstIndex = 1;  // register i resets to i

  function automatic int unsigned log2(input int unsigned n);
    int unsigned res;
    res = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register 2-bit pending-write counters with flush, sticky overflow
// and per-read-port busy evaluation.
//   i_issue_valid/i_issue_reg   : decode issues an instruction writing i_issue_reg
//   i_retire_valid/i_retire_reg : writeback retires (squashed slots still retire)
//   i_flush                     : clear all counters
//   i_read_reg / o_read_busy    : per-port source index and its busy flag
//   o_sb_overflow               : sticky, an issue hit a saturated counter
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_issue_valid,
  input  logic [AW-1:0]       i_issue_reg,
  input  logic                i_retire_valid,
  input  logic [AW-1:0]       i_retire_reg,
  input  logic                i_flush,
  input  logic [NREAD*AW-1:0] i_read_reg,
  output logic [NREAD-1:0]    o_read_busy,
  output logic                o_sb_overflow
);

  localparam logic [CntW-1:0] CntSat = CntW'(CntMax);

  logic [CntW-1:0]  r_cnt    [NREGS];
  logic [CntW-1:0]  w_cnt_d  [NREGS];
  logic [NREGS-1:0] w_iss;
  logic [NREGS-1:0] w_ret;
  logic             w_ovf_hit;
  logic             r_overflow;
  logic [AW-1:0]    w_rd_idx [NREAD];

  // Decode issue/retire per register; register 0 is inert when hardwired to zero.
  always_comb begin
    w_iss = '0;
    w_ret = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      if (!(ZERO_REG != 0 && r == 0)) begin
        w_iss[r] = i_issue_valid  && (i_issue_reg  == AW'(r));
        w_ret[r] = i_retire_valid && (i_retire_reg == AW'(r));
      end
    end
  end

  always_comb begin
    w_ovf_hit = 1'b0;
    for (int r = 0; r < int'(NREGS); r++) begin
      w_cnt_d[r] = r_cnt[r];
      if (i_flush) begin
        w_cnt_d[r] = '0;
      end else if (w_iss[r] && w_ret[r]) begin
        w_cnt_d[r] = r_cnt[r];
      end else if (w_iss[r]) begin
        if (r_cnt[r] == CntSat) begin
          w_ovf_hit = 1'b1;
        end else begin
          w_cnt_d[r] = r_cnt[r] + 1'b1;
        end
      end else if (w_ret[r] && (r_cnt[r] != '0)) begin
        w_cnt_d[r] = r_cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        r_cnt[r] <= '0;
      end
      r_overflow <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        r_cnt[r] <= w_cnt_d[r];
      end
      if (w_ovf_hit) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A last outstanding write retiring this cycle is satisfied by the bypass path.
  always_comb begin
    o_read_busy = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      w_rd_idx[p] = i_read_reg[p*AW +: AW];
      o_read_busy[p] = (r_cnt[w_rd_idx[p]] != '0) &&
                       !((r_cnt[w_rd_idx[p]] == CntW'(1)) && w_ret[w_rd_idx[p]]);
      if (ZERO_REG != 0 && w_rd_idx[p] == '0) begin
        o_read_busy[p] = 1'b0;
      end
    end
  end

  assign o_sb_overflow = r_overflow;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-through bypass and pending-write scoreboard.
//   writeEnable/writeReg/writeData/nop : writeback-stage write (nop squashes the data write)
//   readReg/readData/readBusy          : NREAD combinational decode-stage read ports
//   issueValid/issueReg                : decode issues an instruction with a destination
//   flush                              : drop all pending-write tracking
//   sbOverflow                         : sticky scoreboard saturation flag
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned RESET_INIT = 1,
  localparam int unsigned AW        = log2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic [AW-1:0]         writeReg,
  input  logic [XLEN-1:0]       writeData,
  input  logic                  nop,
  input  logic [NREAD*AW-1:0]   readReg,
  output logic [NREAD*XLEN-1:0] readData,
  output logic [NREAD-1:0]      readBusy,
  input  logic                  issueValid,
  input  logic [AW-1:0]         issueReg,
  input  logic                  flush,
  output logic                  sbOverflow
);

  logic [XLEN-1:0] r_mem [NREGS];
  logic            w_wb_fire;
  logic [AW-1:0]   w_rd_idx [NREAD];

  assign w_wb_fire = writeEnable && !nop && !(ZERO_REG != 0 && writeReg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_mem[i] <= (RESET_INIT == RstIndex) ? XLEN'(i) : '0;
      end
    end else if (w_wb_fire) begin
      r_mem[writeReg] <= writeData;
    end
  end

  always_comb begin
    readData = '0;
    for (int p = 0; p < int'(NREAD); p++) begin
      w_rd_idx[p] = readReg[p*AW +: AW];
      if (ZERO_REG != 0 && w_rd_idx[p] == '0) begin
        readData[p*XLEN +: XLEN] = '0;
      end else if (w_wb_fire && writeReg == w_rd_idx[p]) begin
        readData[p*XLEN +: XLEN] = writeData;
      end else begin
        readData[p*XLEN +: XLEN] = r_mem[w_rd_idx[p]];
      end
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .i_issue_valid  (issueValid),
    .i_issue_reg    (issueReg),
    .i_retire_valid (writeEnable),
    .i_retire_reg   (writeReg),
    .i_flush        (flush),
    .i_read_reg     (readReg),
    .o_read_busy    (readBusy),
    .o_sb_overflow  (sbOverflow)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        writeEnable;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        nop;
  logic [9:0]  readReg;
  logic [63:0] readData;
  logic [1:0]  readBusy;
  logic        issueValid;
  logic [4:0]  issueReg;
  logic        flush;
  logic        sbOverflow;

  int n_checks;
  int n_errors;

  regfile_sb #(
    .XLEN       (32),
    .NREGS      (32),
    .NREAD      (2),
    .ZERO_REG   (1),
    .RESET_INIT (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .nop         (nop),
    .readReg     (readReg),
    .readData    (readData),
    .readBusy    (readBusy),
    .issueValid  (issueValid),
    .issueReg    (issueReg),
    .flush       (flush),
    .sbOverflow  (sbOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and clear one-shot controls.
  task automatic step();
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    nop         = 1'b0;
    issueValid  = 1'b0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
    readReg = {b, a};
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic n);
    writeEnable = 1'b1;
    writeReg    = r;
    writeData   = d;
    nop         = n;
  endtask

  task automatic iss(input logic [4:0] r);
    issueValid = 1'b1;
    issueReg   = r;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    writeEnable = 1'b0; writeReg = '0; writeData = '0; nop = 1'b0;
    readReg = '0; issueValid = 1'b0; issueReg = '0; flush = 1'b0;
    step();

    // Reset contents: register i holds i
    set_rd(5'd5, 5'd31);
    check_eq("rst_rd5", readData[31:0], 32'd5);
    check_eq("rst_rd31", readData[63:32], 32'd31);
    check_eq("rst_busy", {30'd0, readBusy}, 32'd0);
    check_eq("rst_ovf", {31'd0, sbOverflow}, 32'd0);

    // Bypass, both ports on the same index
    wr(5'd7, 32'hDEADBEEF, 1'b0);
    set_rd(5'd7, 5'd7);
    check_eq("byp_p0", readData[31:0], 32'hDEADBEEF);
    check_eq("byp_p1", readData[63:32], 32'hDEADBEEF);
    step();
    set_rd(5'd7, 5'd6);
    check_eq("arr_rd7", readData[31:0], 32'hDEADBEEF);
    check_eq("arr_rd6", readData[63:32], 32'd6);

    // Zero register ignores write and issue
    wr(5'd0, 32'h1234, 1'b0);
    iss(5'd0);
    set_rd(5'd0, 5'd0);
    check_eq("zero_byp", readData[31:0], 32'd0);
    step();
    set_rd(5'd0, 5'd0);
    check_eq("zero_rd", readData[31:0], 32'd0);
    check_eq("zero_busy", {30'd0, readBusy}, 32'd0);

    // Nop write releases the counter but not the data
    iss(5'd3);
    step();
    set_rd(5'd3, 5'd3);
    check_eq("nop_busy_pre", {30'd0, readBusy}, 32'd3);
    wr(5'd3, 32'd9, 1'b1);
    set_rd(5'd3, 5'd3);
    check_eq("nop_nobyp", readData[31:0], 32'd3);
    check_eq("nop_busy_ret", {30'd0, readBusy}, 32'd0);
    step();
    set_rd(5'd3, 5'd3);
    check_eq("nop_rd", readData[31:0], 32'd3);
    check_eq("nop_busy_post", {30'd0, readBusy}, 32'd0);

    // Scoreboard on register 4: three issues, three retires
    for (int i = 0; i < 3; i++) begin
      iss(5'd4);
      step();
    end
    set_rd(5'd4, 5'd5);
    check_eq("sb_busy3", {30'd0, readBusy}, 32'd1);
    wr(5'd4, 32'h11, 1'b0);
    set_rd(5'd4, 5'd5);
    check_eq("sb_ret1", {31'd0, readBusy[0]}, 32'd1);
    step();
    wr(5'd4, 32'h22, 1'b0);
    set_rd(5'd4, 5'd5);
    check_eq("sb_ret2", {31'd0, readBusy[0]}, 32'd1);
    step();
    wr(5'd4, 32'hA5A5, 1'b0);
    set_rd(5'd4, 5'd5);
    check_eq("sb_ret3_busy", {31'd0, readBusy[0]}, 32'd0);
    check_eq("sb_ret3_byp", readData[31:0], 32'hA5A5);
    step();
    set_rd(5'd4, 5'd5);
    check_eq("sb_idle_busy", {31'd0, readBusy[0]}, 32'd0);
    check_eq("sb_idle_rd", readData[31:0], 32'hA5A5);

    // Retire at zero stays zero: a following single issue must not overflow
    wr(5'd4, 32'hA5A5, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      iss(5'd4);
      step();
    end
    check_eq("ovf_pre", {31'd0, sbOverflow}, 32'd0);
    // Issue and retire together at saturation: unchanged, no overflow
    iss(5'd4);
    wr(5'd4, 32'hA5A5, 1'b0);
    step();
    check_eq("ovf_issret", {31'd0, sbOverflow}, 32'd0);
    iss(5'd4);
    step();
    check_eq("ovf_set", {31'd0, sbOverflow}, 32'd1);
    step();
    step();
    check_eq("ovf_sticky", {31'd0, sbOverflow}, 32'd1);

    // Flush with a concurrent retire of 2
    flush = 1'b1;
    step();
    iss(5'd2);
    step();
    iss(5'd6);
    step();
    set_rd(5'd2, 5'd6);
    check_eq("fl_busy_pre", {30'd0, readBusy}, 32'd3);
    flush = 1'b1;
    wr(5'd2, 32'h22, 1'b0);
    set_rd(5'd2, 5'd6);
    check_eq("fl_busy_cyc", {30'd0, readBusy}, 32'd2);
    step();
    set_rd(5'd2, 5'd6);
    check_eq("fl_busy_post", {30'd0, readBusy}, 32'd0);
    check_eq("fl_rd2", readData[31:0], 32'h22);
    check_eq("fl_ovf", {31'd0, sbOverflow}, 32'd1);

    // Reset overrides write and issue in the same cycle
    rst = 1'b1;
    wr(5'd5, 32'hFFFF, 1'b0);
    iss(5'd5);
    step();
    set_rd(5'd5, 5'd7);
    check_eq("rst2_rd5", readData[31:0], 32'd5);
    check_eq("rst2_rd7", readData[63:32], 32'd7);
    check_eq("rst2_busy", {30'd0, readBusy}, 32'd0);
    check_eq("rst2_ovf", {31'd0, sbOverflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
